// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: in-order instruction buffer between fetch and decode with stall, flush and overflow
module fetch_inst_queue #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int DEPTH        = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_instruction,
  input  logic [ADDRESS_BITS-1:0] in_pc,
  output logic                    fetch_stall,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_instruction,
  output logic [ADDRESS_BITS-1:0] out_pc,
  input  logic                    out_ready,
  output logic                    overflow,
  input  logic                    report
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_WIDTH-1:0]   r_instr [DEPTH];
  logic [ADDRESS_BITS-1:0] r_pc    [DEPTH];
  logic [PW-1:0]           r_wr, r_rd;
  logic [CW-1:0]           r_count;
  logic                    r_squash, r_overflow;
  logic                    w_pop, w_push, w_full, w_drop;
  assign w_full          = r_count == CW'(DEPTH);
  assign w_pop           = out_valid & out_ready & ~flush;
  assign w_push          = in_valid & ~r_squash & ~flush & (~w_full | w_pop);
  assign w_drop          = in_valid & ~r_squash & ~flush & w_full & ~w_pop;
  assign out_valid       = r_count != '0;
  assign out_instruction = out_valid ? r_instr[r_rd] : '0;
  assign out_pc          = out_valid ? r_pc[r_rd] : '0;
  assign fetch_stall     = r_count >= CW'(DEPTH - 1);
  assign overflow        = r_overflow;
  // storage write; entries need no reset because count gates visibility
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_instr[r_wr] <= in_instruction;
      r_pc[r_wr]    <= in_pc;
    end
  end
  // pointers, occupancy, post-redirect squash window and sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_squash   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_squash <= flush;
      if (flush) begin
        r_wr    <= '0;
        r_rd    <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + PW'(1);
        if (w_pop) r_rd <= r_rd + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end
`ifndef SYNTHESIS
  logic [31:0] r_cycle;
  // simulation-only state dump for debug
  always_ff @(posedge clock) begin
    r_cycle <= reset ? '0 : r_cycle + 32'd1;
    if (report)
      $display("Core %0d fetch queue: cycle=%0d count=%0d wr=%0d rd=%0d squash=%0b head=%h@%h stall=%0b overflow=%0b",
               CORE, r_cycle, r_count, r_wr, r_rd, r_squash, out_instruction, out_pc, fetch_stall, r_overflow);
  end
`endif
endmodule
